// File: rtl/scale_mux_arb.sv
// Two-source arbitrating mux with a one-word registered output stage.
// Alternating priority breaks ties; per-source saturating acceptance counters.
module scale_mux_arb #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in_a,
  input  logic             valid_a,
  output logic             ready_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             valid_b,
  output logic             ready_b,
  output logic [WIDTH-1:0] out,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             sel_a,
  output logic [7:0]       cnt_a,
  output logic [7:0]       cnt_b
);

  logic load_en;
  logic grant_a;
  logic grant_b;
  logic prio_a;

  function automatic logic [7:0] sat_inc(input logic [7:0] c);
    return (c == 8'hFF) ? c : c + 8'd1;
  endfunction

  assign load_en = !out_valid || out_ready;

  always_comb begin
    grant_a = 1'b0;
    grant_b = 1'b0;
    if (load_en) begin
      if (valid_a && (!valid_b || prio_a))
        grant_a = 1'b1;
      else if (valid_b)
        grant_b = 1'b1;
    end
  end

  // Reset gating keeps both sources stalled while the block is held in reset.
  assign ready_a = rst_n && grant_a;
  assign ready_b = rst_n && grant_b;

  // Output stage: load on grant, otherwise drain when downstream consumes.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out       <= '0;
      out_valid <= 1'b0;
      sel_a     <= 1'b0;
      prio_a    <= 1'b1;
      cnt_a     <= 8'd0;
      cnt_b     <= 8'd0;
    end else begin
      if (grant_a || grant_b) begin
        out       <= grant_a ? in_a : in_b;
        out_valid <= 1'b1;
        sel_a     <= grant_a;
        prio_a    <= grant_b;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
      if (grant_a)
        cnt_a <= sat_inc(cnt_a);
      if (grant_b)
        cnt_b <= sat_inc(cnt_b);
    end
  end

endmodule

// File: tb/tb_scale_mux_arb.sv
// Self-checking bench for scale_mux_arb: directed scenarios plus randomized
// traffic compared against a transaction-level reference model.
module tb_scale_mux_arb;
  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [W-1:0] in_a = '0;
  logic         valid_a = 1'b0;
  logic         ready_a;
  logic [W-1:0] in_b = '0;
  logic         valid_b = 1'b0;
  logic         ready_b;
  logic [W-1:0] out;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic         sel_a;
  logic [7:0]   cnt_a;
  logic [7:0]   cnt_b;

  int checks = 0;
  int errors = 0;

  // Reference model state: last accepted word, whether it is unconsumed,
  // which source wins the next tie, and unbounded acceptance totals.
  logic [W-1:0] m_word;
  bit           m_from_a;
  bit           m_pending;
  bit           m_a_next;
  int           m_tot_a;
  int           m_tot_b;

  bit exp_ra, exp_rb, obs_ra, obs_rb;

  always #5 clk = ~clk;

  scale_mux_arb #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_a(in_a), .valid_a(valid_a), .ready_a(ready_a),
    .in_b(in_b), .valid_b(valid_b), .ready_b(ready_b),
    .out(out), .out_valid(out_valid), .out_ready(out_ready),
    .sel_a(sel_a), .cnt_a(cnt_a), .cnt_b(cnt_b)
  );

  function automatic logic [7:0] sat(input int n);
    return (n > 255) ? 8'hFF : n[7:0];
  endfunction

  task automatic model_clear();
    m_word = '0; m_from_a = 0; m_pending = 0; m_a_next = 1;
    m_tot_a = 0; m_tot_b = 0;
  endtask

  // One clock: drive at negedge, record ready, advance the model past posedge.
  task automatic cycle(input bit r, input bit va, input logic [W-1:0] a,
                       input bit vb, input logic [W-1:0] b, input bit ordy);
    bit room, take_a, take_b;
    @(negedge clk);
    rst_n = r; valid_a = va; in_a = a; valid_b = vb; in_b = b; out_ready = ordy;
    room   = !m_pending || ordy;
    take_a = r && room && va && (!vb || m_a_next);
    take_b = r && room && vb && !take_a;
    exp_ra = take_a; exp_rb = take_b;
    #1;
    obs_ra = ready_a; obs_rb = ready_b;
    @(posedge clk); #1;
    if (!r) begin
      model_clear();
    end else if (take_a || take_b) begin
      m_word    = take_a ? a : b;
      m_from_a  = take_a;
      m_pending = 1;
      m_a_next  = take_b;
      if (take_a) m_tot_a++; else m_tot_b++;
    end else if (ordy) begin
      m_pending = 0;
    end
  endtask

  task automatic test_reset();
    cycle(0, 1, 16'hFFFF, 1, 16'hFFFF, 1);
    checks++; if (obs_ra !== 1'b0 || obs_rb !== 1'b0) begin errors++;
      $display("FAIL reset_ready: got a=%b b=%b want 0 0", obs_ra, obs_rb); end
    checks++; if (out !== 16'h0 || out_valid !== 1'b0 || sel_a !== 1'b0) begin errors++;
      $display("FAIL reset_out: got out=%h v=%b sel=%b want 0000 0 0", out, out_valid, sel_a); end
    checks++; if (cnt_a !== 8'd0 || cnt_b !== 8'd0) begin errors++;
      $display("FAIL reset_cnt: got %0d %0d want 0 0", cnt_a, cnt_b); end
  endtask

  task automatic test_alternate();
    logic [W-1:0] exp_seq [4];
    bit exp_sel [4];
    exp_seq = '{16'hAAAA, 16'h5555, 16'hAAAA, 16'h5555};
    exp_sel = '{1, 0, 1, 0};
    cycle(0, 0, '0, 0, '0, 0);
    for (int i = 0; i < 4; i++) begin
      cycle(1, 1, 16'hAAAA, 1, 16'h5555, 1);
      checks++; if (out !== exp_seq[i] || sel_a !== exp_sel[i] || out_valid !== 1'b1) begin errors++;
        $display("FAIL alt_seq[%0d]: got out=%h sel=%b v=%b want %h %b 1", i, out, sel_a, out_valid, exp_seq[i], exp_sel[i]); end
    end
    checks++; if (cnt_a !== 8'd2 || cnt_b !== 8'd2) begin errors++;
      $display("FAIL alt_cnt: got %0d %0d want 2 2", cnt_a, cnt_b); end
  endtask

  task automatic test_only_b();
    cycle(0, 0, '0, 0, '0, 0);
    for (int i = 0; i < 3; i++) begin
      cycle(1, 0, 16'hDEAD, 1, 16'h1234, 1);
      checks++; if (obs_rb !== 1'b1 || obs_ra !== 1'b0) begin errors++;
        $display("FAIL onlyb_ready[%0d]: got a=%b b=%b want 0 1", i, obs_ra, obs_rb); end
      checks++; if (out !== 16'h1234 || sel_a !== 1'b0) begin errors++;
        $display("FAIL onlyb_out[%0d]: got %h sel=%b want 1234 0", i, out, sel_a); end
    end
    checks++; if (cnt_b !== 8'd3) begin errors++;
      $display("FAIL onlyb_cnt: got %0d want 3", cnt_b); end
  endtask

  task automatic test_backpressure();
    logic [7:0] ca, cb;
    cycle(1, 1, 16'h0F0F, 0, '0, 1);
    ca = cnt_a; cb = cnt_b;
    for (int i = 0; i < 5; i++) begin
      cycle(1, 1, $urandom, 1, $urandom, 0);
      checks++; if (obs_ra !== 1'b0 || obs_rb !== 1'b0) begin errors++;
        $display("FAIL bp_ready[%0d]: got a=%b b=%b want 0 0", i, obs_ra, obs_rb); end
      checks++; if (out !== 16'h0F0F || sel_a !== 1'b1 || out_valid !== 1'b1) begin errors++;
        $display("FAIL bp_hold[%0d]: got %h sel=%b v=%b want 0f0f 1 1", i, out, sel_a, out_valid); end
      checks++; if (cnt_a !== ca || cnt_b !== cb) begin errors++;
        $display("FAIL bp_cnt[%0d]: got %0d %0d want %0d %0d", i, cnt_a, cnt_b, ca, cb); end
    end
  endtask

  task automatic test_drain();
    cycle(1, 0, '0, 0, '0, 1);
    checks++; if (out_valid !== 1'b0 || out !== 16'h0F0F || sel_a !== 1'b1) begin errors++;
      $display("FAIL drain: got v=%b out=%h sel=%b want 0 0f0f 1", out_valid, out, sel_a); end
  endtask

  task automatic test_saturate();
    cycle(0, 0, '0, 0, '0, 0);
    for (int i = 1; i <= 300; i++) begin
      cycle(1, 1, i[W-1:0], 0, '0, 1);
      if (i == 254 || i == 255 || i == 256 || i == 300) begin
        checks++; if (cnt_a !== sat(i)) begin errors++;
          $display("FAIL sat_cnt[%0d]: got %0d want %0d", i, cnt_a, sat(i)); end
      end
    end
  endtask

  task automatic test_reset_mid();
    cycle(1, 0, '0, 1, 16'hBEEF, 1);
    cycle(1, 1, '0, 1, '0, 0);
    cycle(0, 1, 16'h1111, 1, 16'h2222, 0);
    checks++; if (obs_ra !== 1'b0 || obs_rb !== 1'b0) begin errors++;
      $display("FAIL rmid_ready: got a=%b b=%b want 0 0", obs_ra, obs_rb); end
    checks++; if (out !== 16'h0 || out_valid !== 1'b0 || cnt_b !== 8'd0) begin errors++;
      $display("FAIL rmid_clear: got out=%h v=%b cb=%0d want 0 0 0", out, out_valid, cnt_b); end
    cycle(1, 1, 16'h1111, 1, 16'h2222, 1);
    checks++; if (obs_ra !== 1'b1 || out !== 16'h1111 || sel_a !== 1'b1) begin errors++;
      $display("FAIL rmid_first: got ra=%b out=%h sel=%b want 1 1111 1", obs_ra, out, sel_a); end
  endtask

  task automatic test_random();
    bit r, va, vb, ordy;
    for (int i = 0; i < 400; i++) begin
      r    = ($urandom_range(0, 49) != 0);
      va   = $urandom_range(0, 1);
      vb   = $urandom_range(0, 1);
      ordy = ($urandom_range(0, 3) != 0);
      cycle(r, va, $urandom, vb, $urandom, ordy);
      checks++; if (obs_ra !== exp_ra || obs_rb !== exp_rb) begin errors++;
        $display("FAIL rnd_ready[%0d]: got a=%b b=%b want %b %b", i, obs_ra, obs_rb, exp_ra, exp_rb); end
      checks++; if (out !== m_word || out_valid !== m_pending || sel_a !== m_from_a) begin errors++;
        $display("FAIL rnd_out[%0d]: got %h v=%b sel=%b want %h %b %b", i, out, out_valid, sel_a, m_word, m_pending, m_from_a); end
      checks++; if (cnt_a !== sat(m_tot_a) || cnt_b !== sat(m_tot_b)) begin errors++;
        $display("FAIL rnd_cnt[%0d]: got %0d %0d want %0d %0d", i, cnt_a, cnt_b, sat(m_tot_a), sat(m_tot_b)); end
    end
  endtask

  initial begin
    model_clear();
    test_reset();
    test_alternate();
    test_only_b();
    test_backpressure();
    test_drain();
    test_saturate();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end
endmodule

// File: doc/scale_mux_arb.md
SCALE_MUX_ARB -- requirements
Module: scale_mux_arb

Interface
REQ-001 The module SHALL have parameter WIDTH, default 16, giving the data width of both inputs and the output.
REQ-002 The module SHALL have port clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-003 The module SHALL have port rst_n, input, 1 bit: synchronous, active-low reset, sampled on the rising edge of clk.
REQ-004 The module SHALL have port in_a, input, WIDTH bits: source A data.
REQ-005 The module SHALL have port valid_a, input, 1 bit: source A data present.
REQ-006 The module SHALL have port ready_a, output, 1 bit: source A word accepted this cycle.
REQ-007 The module SHALL have port in_b, input, WIDTH bits: source B data.
REQ-008 The module SHALL have port valid_b, input, 1 bit: source B data present.
REQ-009 The module SHALL have port ready_b, output, 1 bit: source B word accepted this cycle.
REQ-010 The module SHALL have port out, output, WIDTH bits: registered selected data.
REQ-011 The module SHALL have port out_valid, output, 1 bit: out holds an unconsumed word.
REQ-012 The module SHALL have port out_ready, input, 1 bit: downstream accepts out this cycle.
REQ-013 The module SHALL have port sel_a, output, 1 bit: registered; 1 means the word in out came from A, 0 means it came from B.
REQ-014 The module SHALL have ports cnt_a and cnt_b, output, 8 bits each: saturating counts of words accepted from A and from B.

Function
REQ-015 Internal load enable SHALL be defined as load_en = !out_valid || out_ready.
REQ-016 A transfer on a port SHALL occur only in a cycle where both its valid and its ready are 1.
REQ-017 Grant rules when load_en=1:
- Only valid_a=1: grant A.
- Only valid_b=1: grant B.
- Both valid: grant according to the priority pointer prio_a (1 = A wins).
- Neither valid: no grant.
REQ-018 ready_a SHALL equal load_en && grant_a, combinationally; ready_b SHALL equal load_en && grant_b; both are never 1 in the same cycle.
REQ-019 On a grant, the next edge SHALL load the granted data into out, set out_valid=1, and set sel_a=grant_a.
REQ-020 Latency SHALL be 1 cycle from input transfer to out_valid; sustained throughput SHALL be one word per cycle.
REQ-021 After a grant to A, prio_a SHALL become 0; after a grant to B, prio_a SHALL become 1; with no grant, prio_a SHALL hold.
REQ-022 If out_valid=1 and out_ready=1 with no grant, out_valid SHALL clear at the next edge while out and sel_a hold their values.
REQ-023 While out_valid=1 and out_ready=0, out and sel_a SHALL remain stable and ready_a and ready_b SHALL be 0 (backpressure).
REQ-024 cnt_a SHALL increment on each A transfer and saturate at 8'hFF; cnt_b SHALL behave identically for B.
REQ-025 Sources SHALL NOT be required to hold valid; the block SHALL make no assumption about valid persistence.

Reset
REQ-026 When rst_n=0 at a clock edge, the block SHALL set out=0, out_valid=0, sel_a=0, prio_a=1, cnt_a=0 and cnt_b=0.
REQ-027 While rst_n=0, ready_a and ready_b SHALL be 0.
REQ-028 Reset asserted mid-operation SHALL discard any held word without a downstream transfer.

Verification
REQ-029 Reset, then valid_a=valid_b=1 with in_a=16'hAAAA and in_b=16'h5555, out_ready=1 for 4 cycles -> out sequence AAAA,5555,AAAA,5555; sel_a sequence 1,0,1,0; cnt_a=2; cnt_b=2.
REQ-030 Only valid_b=1 with in_b=16'h1234 for 3 cycles -> each cycle ready_b=1 and ready_a=0; out=1234; sel_a=0; cnt_b=3.
REQ-031 Load one word, then hold out_ready=0 for 5 cycles with both sources valid -> out stable, ready_a=ready_b=0, counters unchanged.
REQ-032 Hold out_valid=1, then drive out_ready=1 with no valid input -> out_valid=0 on the next edge, out unchanged.
REQ-033 Drive 300 A transfers -> cnt_a=8'hFF, with no wrap to 0.
REQ-034 Assert rst_n=0 while out_valid=1 -> next edge gives out=0, out_valid=0, prio_a=1; the first contended grant after reset goes to A.
